mem_responder: RTL

- Memory-side responder for the multicycle RISC-V core: it answers load/store requests the core's control FSM issues.
- Accepts one request at a time over a valid/ready handshake and holds an internal word-organised data array.
- Performs RV32I byte/halfword/word stores with byte-lane merging, and loads with sign/zero extension.
- Adds a configurable number of wait states and flags misaligned, out-of-range or illegal-size accesses.

---
 rtl/mem_responder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle RV32I core: one load/store request at a time,
// with programmable wait states, byte-lane merging on stores and extension on loads.
module mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t state, state_next;
   logic [3:0]    counter;
   logic [31:0]   addr_q, wdata_q;
   logic          we_q;
   logic [2:0]    funct3_q;
   logic [31:0]   mem [DEPTH_WORDS];
   logic [AW-1:0] word_idx;
   logic          do_access;
   logic          size_err, align_err, range_err, access_err;
   logic [31:0]   rd_word, load_data, store_data;
   logic [7:0]    rd_byte;
   logic [15:0]   rd_half;
   logic [3:0]    store_mask;

   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      do_access  = 1'b0;
      case (state)
         IDLE: begin
            req_ready = !rst;
            if (req_valid) state_next = ACCESS;
         end
         ACCESS: begin
            if (counter == 4'd0) begin
               do_access  = 1'b1;
               state_next = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // The latched request is what the access uses; later input changes are ignored.
   always_ff @(posedge clk) begin
      if (!rst && state == IDLE && req_valid) begin
         addr_q   <= req_addr;
         we_q     <= req_we;
         funct3_q <= req_funct3;
         wdata_q  <= req_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         counter   <= 4'd0;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end else if (state == IDLE && req_valid) begin
         counter <= 4'(WAIT_STATES);
      end else if (state == ACCESS) begin
         if (counter != 4'd0) begin
            counter <= counter - 4'd1;
         end else begin
            rsp_err   <= access_err;
            rsp_rdata <= (access_err || we_q) ? 32'd0 : load_data;
         end
      end
   end

   always_comb begin
      size_err = 1'b0;
      case (funct3_q)
         3'b000, 3'b001, 3'b010: size_err = 1'b0;
         3'b100, 3'b101:         size_err = we_q;
         default:                size_err = 1'b1;
      endcase
      align_err  = (funct3_q[1:0] == 2'b01 && addr_q[0]) ||
                   (funct3_q == 3'b010 && addr_q[1:0] != 2'b00);
      range_err  = {2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS);
      access_err = size_err | align_err | range_err;
   end

   assign word_idx = addr_q[AW+1:2];
   assign rd_word  = mem[word_idx];
   assign rd_half  = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

   always_comb begin
      rd_byte = rd_word[7:0];
      case (addr_q[1:0])
         2'b00: rd_byte = rd_word[7:0];
         2'b01: rd_byte = rd_word[15:8];
         2'b10: rd_byte = rd_word[23:16];
         2'b11: rd_byte = rd_word[31:24];
         default: rd_byte = rd_word[7:0];
      endcase
   end

   always_comb begin
      load_data = rd_word;
      case (funct3_q)
         3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
         3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
         3'b100:  load_data = {24'd0, rd_byte};
         3'b101:  load_data = {16'd0, rd_half};
         default: load_data = rd_word;
      endcase
   end

   // Store data is replicated across lanes so the mask alone selects what lands.
   always_comb begin
      store_mask = 4'b1111;
      store_data = wdata_q;
      case (funct3_q[1:0])
         2'b00: begin
            store_mask = 4'b0001 << addr_q[1:0];
            store_data = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            store_mask = addr_q[1] ? 4'b1100 : 4'b0011;
            store_data = {2{wdata_q[15:0]}};
         end
         default: begin
            store_mask = 4'b1111;
            store_data = wdata_q;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst && do_access && we_q && !access_err) begin
         for (int b = 0; b < 4; b++) begin
            if (store_mask[b]) mem[word_idx][8*b +: 8] <= store_data[8*b +: 8];
         end
      end
   end

endmodule
